uart_cmd_framer: RTL
====================

Name: uart_cmd_framer

Overview:
- Sequences the byte stream from the UART receiver into fixed 4-byte command packets: SYNC, CMD, ARG, CHK.
- Validates each packet, enforces an inter-byte timeout, and presents good commands to game/control logic over a valid/ready handshake with a one-entry holding register.
- Keeps saturating counters for checksum errors, timeouts and dropped (overflowed) commands for debug readout.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- TIMEOUT_CLKS, 21700, maximum clocks between consecutive packet bytes; 10 byte times at 217 clks/bit. Must be ≥ 2.
- CNT_W, 8, width of each saturating error counter.

Ports:
- i_Clk  in  1  system clock; single clock domain.
- i_Rst  in  1  synchronous, active-high reset.
- i_RX_DV  in  1  byte-valid strobe from the UART receiver; one-cycle pulse.
- i_RX_Byte  in  8  received byte, qualified by i_RX_DV.
- o_Cmd_Valid  out  1  command available; held until accepted.
- i_Cmd_Ready  in  1  consumer accepts the command when high with o_Cmd_Valid.
- o_Cmd  out  8  command opcode; stable while o_Cmd_Valid.
- o_Arg  out  8  command argument; stable while o_Cmd_Valid.
- o_Chk_Err_Count  out  CNT_W  packets with a bad checksum.
- o_Timeout_Count  out  CNT_W  packets aborted by the inter-byte timeout.
- o_Drop_Count  out  CNT_W  good packets lost because the holding register was occupied.

Behaviour:
- Reset: all outputs are registered and cleared on the first i_Clk edge with i_Rst=1.
  - o_Cmd_Valid=0, o_Cmd=0, o_Arg=0, all counters=0.
  - State=WAIT_SYNC, timer=0.
  - Reset mid-packet discards partial bytes and any pending command.
- FSM states: WAIT_SYNC, GET_CMD, GET_ARG, GET_CHK.
  - WAIT_SYNC: on i_RX_DV, if byte==SYNC_BYTE go to GET_CMD; other bytes are ignored silently, with no counter change.
  - GET_CMD: on i_RX_DV, latch the byte into the cmd shadow register and go to GET_ARG. A byte equal to SYNC_BYTE is treated as data; there is no resync.
  - GET_ARG: on i_RX_DV, latch the arg shadow register and go to GET_CHK.
  - GET_CHK: on i_RX_DV, compare the byte with cmd^arg (8-bit XOR), commit or flag, then go to WAIT_SYNC.
- Checksum mismatch: increment o_Chk_Err_Count and discard the packet.
- Commit (checksum match):
  - If o_Cmd_Valid==0, or o_Cmd_Valid&&i_Cmd_Ready in the same cycle: load o_Cmd/o_Arg and set o_Cmd_Valid=1 on the next edge.
  - Otherwise the held command is kept unchanged, the new one is dropped, and o_Drop_Count is incremented.
- Latency: o_Cmd_Valid rises on the clock edge that samples the CHK byte's i_RX_DV. It is visible one cycle after the strobe cycle.
- Handshake:
  - o_Cmd_Valid clears on the edge where o_Cmd_Valid&&i_Cmd_Ready, unless a commit occurs in the same cycle (see Commit).
  - o_Cmd/o_Arg never change while o_Cmd_Valid=1 without acceptance.
- Timeout:
  - The timer is cleared in WAIT_SYNC and on every i_RX_DV.
  - In other states it increments each cycle.
  - When the timer==TIMEOUT_CLKS-1 and no i_RX_DV is present: go to WAIT_SYNC, increment o_Timeout_Count, clear the timer.
  - i_RX_DV in the same cycle as expiry wins: the byte is processed normally and no timeout is counted.
- Counters saturate at 2^CNT_W-1 and never wrap. Multiple counters may increment in the same cycle.
- i_RX_DV held high for multiple cycles is treated as one byte per cycle; there is no edge detection.
- Timer width: $clog2(TIMEOUT_CLKS). All arithmetic is unsigned.

Test Plan:
- Reset, then send bytes A5,10,22,32 with ready=1 → o_Cmd_Valid pulses 1 cycle after the CHK strobe; o_Cmd=10, o_Arg=22; all counters 0.
- Send 00,FF,A5,01,02,03 (junk before sync) with ready=0 → one command is held: cmd=01, arg=02, valid stays 1; counters 0. Raise ready for 1 cycle → valid drops.
- Send A5,01,02,04 (bad CHK) → no valid; o_Chk_Err_Count=1. Then send A5,01,02,03 → command accepted normally.
- Send A5,05 and wait TIMEOUT_CLKS cycles → o_Timeout_Count=1, FSM back in WAIT_SYNC. Then send 06,07,01 → ignored (no A5), no valid.
- With ready=0, send two good packets A5,01,02,03 and A5,04,05,01 → held cmd stays 01/02; o_Drop_Count=1. Repeat the second packet in the cycle where ready=1 is accepted → new cmd 04/05 loaded, no drop.
- Mid-packet (after A5,01) assert i_Rst for 1 cycle with a valid command pending → valid=0, outputs 0. Then send 02,03 → ignored. Force 300 bad packets → o_Chk_Err_Count saturates at 255.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: frames UART bytes into SYNC/CMD/ARG/CHK packets,
// holds one good command for a valid/ready consumer, counts errors.
module uart_cmd_framer #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 21700,
    parameter int         CNT_W        = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_RX_DV,
    input  logic [7:0]       i_RX_Byte,
    output logic             o_Cmd_Valid,
    input  logic             i_Cmd_Ready,
    output logic [7:0]       o_Cmd,
    output logic [7:0]       o_Arg,
    output logic [CNT_W-1:0] o_Chk_Err_Count,
    output logic [CNT_W-1:0] o_Timeout_Count,
    output logic [CNT_W-1:0] o_Drop_Count
);

    localparam int TW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_CMD,
        GET_ARG,
        GET_CHK
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic            valid_d;
    logic [7:0]      out_cmd_d, out_arg_d;
    logic            expire;
    logic            chk_inc, to_inc, drop_inc;
    logic            accept;

    // Next-state, timer, commit and counter-increment decisions
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        valid_d   = o_Cmd_Valid;
        out_cmd_d = o_Cmd;
        out_arg_d = o_Arg;
        chk_inc   = 1'b0;
        to_inc    = 1'b0;
        drop_inc  = 1'b0;
        accept    = o_Cmd_Valid && i_Cmd_Ready;
        expire    = (state_q != WAIT_SYNC) && !i_RX_DV &&
                    (timer_q == TW'(TIMEOUT_CLKS - 1));

        if (accept)
            valid_d = 1'b0;

        if (state_q == WAIT_SYNC || i_RX_DV || expire)
            timer_d = '0;
        else
            timer_d = timer_q + TW'(1);

        unique case (state_q)
            WAIT_SYNC: begin
                if (i_RX_DV && i_RX_Byte == SYNC_BYTE)
                    state_d = GET_CMD;
            end
            GET_CMD: begin
                if (i_RX_DV) begin
                    cmd_d   = i_RX_Byte;
                    state_d = GET_ARG;
                end
            end
            GET_ARG: begin
                if (i_RX_DV) begin
                    arg_d   = i_RX_Byte;
                    state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (i_RX_DV) begin
                    state_d = WAIT_SYNC;
                    if (i_RX_Byte != (cmd_q ^ arg_q)) begin
                        chk_inc = 1'b1;
                    end else if (!o_Cmd_Valid || accept) begin
                        valid_d   = 1'b1;
                        out_cmd_d = cmd_q;
                        out_arg_d = arg_q;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        if (expire) begin
            state_d = WAIT_SYNC;
            to_inc  = 1'b1;
        end
    end

    // Framer state, shadow registers and output holding register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= WAIT_SYNC;
            timer_q     <= '0;
            cmd_q       <= '0;
            arg_q       <= '0;
            o_Cmd_Valid <= 1'b0;
            o_Cmd       <= '0;
            o_Arg       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            o_Cmd_Valid <= valid_d;
            o_Cmd       <= out_cmd_d;
            o_Arg       <= out_arg_d;
        end
    end

    // Saturating debug counters; several may step in one cycle
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Chk_Err_Count <= '0;
            o_Timeout_Count <= '0;
            o_Drop_Count    <= '0;
        end else begin
            if (chk_inc && o_Chk_Err_Count != '1)
                o_Chk_Err_Count <= o_Chk_Err_Count + CNT_W'(1);
            if (to_inc && o_Timeout_Count != '1)
                o_Timeout_Count <= o_Timeout_Count + CNT_W'(1);
            if (drop_inc && o_Drop_Count != '1)
                o_Drop_Count <= o_Drop_Count + CNT_W'(1);
        end
    end

endmodule
